// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
// Sequences the mm:ss BCD time display of a microwave oven. It accepts keypad
// digits, counts down once per second while heating, and handles the
// start / pause / clear / door-open events.
//
// Parameters
//   TICK_DIV   clock cycles per one-second tick
//   BEEP_SECS  seconds that done stays high after the count reaches 0:00
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   key_valid  in   1  1-cycle strobe: key holds a digit
//   key        in   4  BCD digit 0-9; values above 9 are ignored
//   start      in   1  1-cycle strobe: start or resume heating
//   pause      in   1  1-cycle strobe: pause heating
//   clear      in   1  1-cycle strobe: abort and zero the time
//   door_open  in   1  level: door is open
//   sec_units  out  4  BCD seconds units (0-9)
//   sec_tens   out  4  BCD seconds tens (0-5)
//   mins       out  4  BCD minutes (0-9)
//   heat_on    out  1  magnetron enable, high exactly while in RUN
//   done       out  1  beeper enable, high exactly while in DONE
//   state      out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
//
// All outputs are registered; every event takes effect on the clock edge that
// samples its strobe. Same-cycle priority: clear > door_open > pause > start >
// key_valid.
// -----------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       door_open,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       heat_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PRESC_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BEEP_W  = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEP_SECS - 1);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] TENS_MAX  = DIGIT_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Displayed time, most significant digit first.
  typedef struct packed {
    logic [DIGIT_W-1:0] mins;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
  } disp_t;

  localparam disp_t DISP_ZERO = '{mins: '0, tens: '0, units: '0};

  // Registered state
  state_t              r_state;
  disp_t               r_disp;
  logic [PRESC_W-1:0]  r_presc;
  logic [BEEP_W-1:0]   r_beep;
  logic                r_heat;
  logic                r_done;

  // Next-state values
  state_t              w_state;
  disp_t               w_disp;
  logic [PRESC_W-1:0]  w_presc;
  logic [BEEP_W-1:0]   w_beep;
  logic                w_heat;
  logic                w_done;

  // Helpers
  logic                w_key_ok;
  logic                w_shift_ok;
  logic                w_time_zero;
  logic                w_tick;
  disp_t               w_shifted;
  disp_t               w_dec;
  logic                w_dec_zero;

  // Key acceptance: a BCD digit, and the old units digit must be a legal tens digit.
  assign w_key_ok    = (key <= DIGIT_MAX);
  assign w_shift_ok  = w_key_ok && (r_disp.units <= TENS_MAX);
  assign w_shifted   = '{mins: r_disp.tens, tens: r_disp.units, units: key};
  assign w_time_zero = (r_disp == DISP_ZERO);
  assign w_tick      = (r_presc == PRESC_LAST);

  // One-second decrement with BCD borrow across the digits.
  always_comb begin
    w_dec = r_disp;
    if (r_disp.units != '0) begin
      w_dec.units = r_disp.units - DIGIT_W'(1);
    end else if (r_disp.tens != '0) begin
      w_dec.tens  = r_disp.tens - DIGIT_W'(1);
      w_dec.units = DIGIT_MAX;
    end else if (r_disp.mins != '0) begin
      w_dec.mins  = r_disp.mins - DIGIT_W'(1);
      w_dec.tens  = TENS_MAX;
      w_dec.units = DIGIT_MAX;
    end
  end

  assign w_dec_zero = (w_dec == DISP_ZERO);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_disp  <= DISP_ZERO;
      r_presc <= '0;
      r_beep  <= '0;
      r_heat  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_disp  <= w_disp;
      r_presc <= w_presc;
      r_beep  <= w_beep;
      r_heat  <= w_heat;
      r_done  <= w_done;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_disp  = r_disp;
    w_presc = r_presc;
    w_beep  = r_beep;

    if (clear) begin
      w_state = ST_IDLE;
      w_disp  = DISP_ZERO;
      w_presc = '0;
      w_beep  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_presc = '0;
          w_beep  = '0;
          if (start) begin
            // A start strobe is consumed even when it cannot start heating.
            if (!door_open && !w_time_zero) begin
              w_state = ST_RUN;
            end
          end else if (key_valid && w_shift_ok) begin
            w_disp = w_shifted;
          end
        end

        ST_RUN: begin
          if (door_open || pause) begin
            w_state = ST_PAUSE;
          end else if (w_tick) begin
            w_presc = '0;
            w_disp  = w_dec;
            if (w_dec_zero) begin
              w_state = ST_DONE;
              w_beep  = '0;
            end
          end else begin
            w_presc = r_presc + PRESC_W'(1);
          end
        end

        ST_PAUSE: begin
          // Digits and prescaler stay frozen; resuming restarts a full second.
          if (start && !door_open) begin
            w_state = ST_RUN;
            w_presc = '0;
          end
        end

        ST_DONE: begin
          if (door_open || start) begin
            w_state = ST_IDLE;
            w_presc = '0;
            w_beep  = '0;
          end else if (w_tick) begin
            w_presc = '0;
            if (r_beep == BEEP_LAST) begin
              w_state = ST_IDLE;
              w_beep  = '0;
            end else begin
              w_beep = r_beep + BEEP_W'(1);
            end
          end else begin
            w_presc = r_presc + PRESC_W'(1);
          end
        end

        default: begin
          w_state = ST_IDLE;
          w_disp  = DISP_ZERO;
          w_presc = '0;
          w_beep  = '0;
        end
      endcase
    end

    w_heat = (w_state == ST_RUN);
    w_done = (w_state == ST_DONE);
  end

  assign sec_units = r_disp.units;
  assign sec_tens  = r_disp.tens;
  assign mins      = r_disp.mins;
  assign heat_on   = r_heat;
  assign done      = r_done;
  assign state     = r_state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microwave_timer_ctrl
// Self-checking bench for microwave_timer_ctrl with TICK_DIV=4, BEEP_SECS=2.
// A table of {inputs, expected outputs} rows is applied one clock per row; the
// expected outputs go into a scoreboard queue when a row is driven and are
// popped and compared one time unit after the sampling edge. A few multi-cycle
// corner cases follow as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_microwave_timer_ctrl;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned BEEP_SECS = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key;
  logic       start;
  logic       pause;
  logic       clear;
  logic       door_open;
  logic [3:0] sec_units;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       heat_on;
  logic       done;
  logic [1:0] state;

  microwave_timer_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .BEEP_SECS (BEEP_SECS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key       (key),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .door_open (door_open),
    .sec_units (sec_units),
    .sec_tens  (sec_tens),
    .mins      (mins),
    .heat_on   (heat_on),
    .done      (done),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs for one clock and the outputs expected after that edge.
  // Expected outputs are packed as {state, mins, tens, units, heat_on, done}.
  typedef struct {
    logic        kv;
    logic [3:0]  k;
    logic        st;
    logic        pa;
    logic        cl;
    logic        dr;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb_exp[$];
  string       sb_name[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] pk(logic [1:0] s, logic [3:0] m, logic [3:0] t, logic [3:0] u);
    return {s, m, t, u, (s == S_RUN), (s == S_DONE)};
  endfunction

  function automatic vec_t mk(string nm, logic kv, logic [3:0] k, logic st, logic pa,
                              logic cl, logic dr, logic [1:0] s, logic [3:0] m,
                              logic [3:0] t, logic [3:0] u);
    vec_t v;
    v.kv = kv; v.k = k; v.st = st; v.pa = pa; v.cl = cl; v.dr = dr;
    v.exp  = pk(s, m, t, u);
    v.name = nm;
    return v;
  endfunction

  // Append n identical rows to the table.
  task automatic add(string nm, logic kv, logic [3:0] k, logic st, logic pa, logic cl,
                     logic dr, logic [1:0] s, logic [3:0] m, logic [3:0] t, logic [3:0] u,
                     int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk(nm, kv, k, st, pa, cl, dr, s, m, t, u));
  endtask

  function automatic logic [15:0] outs();
    return {state, mins, sec_tens, sec_units, heat_on, done};
  endfunction

  task automatic check_pop();
    logic [15:0] e;
    logic [15:0] a;
    string       nm;
    if (sb_exp.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: nothing expected but a check was due");
      return;
    end
    e  = sb_exp.pop_front();
    nm = sb_name.pop_front();
    a  = outs();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d %0h:%0h%0h heat=%0b done=%0b, expected st=%0d %0h:%0h%0h heat=%0b done=%0b",
               nm, a[15:14], a[13:10], a[9:6], a[5:2], a[1], a[0],
               e[15:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
    end
  endtask

  // Drive one row between edges, then compare after the sampling edge.
  task automatic apply(vec_t v);
    @(negedge clk);
    key_valid = v.kv;
    key       = v.k;
    start     = v.st;
    pause     = v.pa;
    clear     = v.cl;
    door_open = v.dr;
    sb_exp.push_back(v.exp);
    sb_name.push_back(v.name);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Cycle-budget watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key = 4'd0; start = 1'b0;
    pause = 1'b0; clear = 1'b0; door_open = 1'b0;

    #3;
    n_tests++;
    if (outs() !== pk(S_IDLE, 4'd0, 4'd0, 4'd0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", outs(), pk(S_IDLE, 4'd0, 4'd0, 4'd0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Keypad entry, rejection rules and start at 0:00.
    add("key1",         1, 4'd1,  0, 0, 0, 0, S_IDLE, 0, 0, 1, 1);
    add("key4",         1, 4'd4,  0, 0, 0, 0, S_IDLE, 0, 1, 4, 1);
    add("key5_145",     1, 4'd5,  0, 0, 0, 0, S_IDLE, 1, 4, 5, 1);
    add("key12_ignore", 1, 4'd12, 0, 0, 0, 0, S_IDLE, 1, 4, 5, 1);
    add("clear_idle",   0, 4'd0,  0, 0, 1, 0, S_IDLE, 0, 0, 0, 1);
    add("start_at_0",   0, 4'd0,  1, 0, 0, 0, S_IDLE, 0, 0, 0, 1);
    add("key7",         1, 4'd7,  0, 0, 0, 0, S_IDLE, 0, 0, 7, 1);
    add("key3_reject",  1, 4'd3,  0, 0, 0, 0, S_IDLE, 0, 0, 7, 1);
    add("clear2",       0, 4'd0,  0, 0, 1, 0, S_IDLE, 0, 0, 0, 1);
    // 0:02 countdown into DONE, beep for 8 cycles, back to IDLE.
    add("key2",         1, 4'd2,  0, 0, 0, 0, S_IDLE, 0, 0, 2, 1);
    add("start_002",    0, 4'd0,  1, 0, 0, 0, S_RUN,  0, 0, 2, 1);
    add("run_002",      0, 4'd0,  0, 0, 0, 0, S_RUN,  0, 0, 2, 3);
    add("tick_001",     0, 4'd0,  0, 0, 0, 0, S_RUN,  0, 0, 1, 1);
    add("run_001",      0, 4'd0,  0, 0, 0, 0, S_RUN,  0, 0, 1, 3);
    add("tick_done",    0, 4'd0,  0, 0, 0, 0, S_DONE, 0, 0, 0, 1);
    add("beeping",      0, 4'd0,  0, 0, 0, 0, S_DONE, 0, 0, 0, 7);
    add("beep_end",     0, 4'd0,  0, 0, 0, 0, S_IDLE, 0, 0, 0, 1);
    // Borrow from minutes: 1:00 -> 0:59.
    add("k1",           1, 4'd1,  0, 0, 0, 0, S_IDLE, 0, 0, 1, 1);
    add("k0",           1, 4'd0,  0, 0, 0, 0, S_IDLE, 0, 1, 0, 1);
    add("k0_100",       1, 4'd0,  0, 0, 0, 0, S_IDLE, 1, 0, 0, 1);
    add("start_100",    0, 4'd0,  1, 0, 0, 0, S_RUN,  1, 0, 0, 1);
    add("run_100",      0, 4'd0,  0, 0, 0, 0, S_RUN,  1, 0, 0, 1);
    add("run_key_ign",  1, 4'd5,  0, 0, 0, 0, S_RUN,  1, 0, 0, 1);
    add("run_100b",     0, 4'd0,  0, 0, 0, 0, S_RUN,  1, 0, 0, 1);
    add("tick_059",     0, 4'd0,  0, 0, 0, 0, S_RUN,  0, 5, 9, 1);
    add("clear_run",    0, 4'd0,  0, 0, 1, 0, S_IDLE, 0, 0, 0, 1);
    // Borrow from tens: 0:10 -> 0:09.
    add("k1b",          1, 4'd1,  0, 0, 0, 0, S_IDLE, 0, 0, 1, 1);
    add("k0_010",       1, 4'd0,  0, 0, 0, 0, S_IDLE, 0, 1, 0, 1);
    add("start_010",    0, 4'd0,  1, 0, 0, 0, S_RUN,  0, 1, 0, 1);
    add("run_010",      0, 4'd0,  0, 0, 0, 0, S_RUN,  0, 1, 0, 3);
    add("tick_009",     0, 4'd0,  0, 0, 0, 0, S_RUN,  0, 0, 9, 1);
    add("clear3",       0, 4'd0,  0, 0, 1, 0, S_IDLE, 0, 0, 0, 1);

    foreach (tbl[i]) apply(tbl[i]);

    // Door open while running, start with door open, resume timing, pause strobe,
    // then clear+start together in PAUSE.
    apply(mk("d_k3",        1, 4'd3, 0, 0, 0, 0, S_IDLE,  0, 0, 3));
    apply(mk("d_k0",        1, 4'd0, 0, 0, 0, 0, S_IDLE,  0, 3, 0));
    apply(mk("d_start",     0, 4'd0, 1, 0, 0, 0, S_RUN,   0, 3, 0));
    for (int i = 0; i < 3; i++) apply(mk("d_run", 0, 4'd0, 0, 0, 0, 0, S_RUN, 0, 3, 0));
    apply(mk("d_tick029",   0, 4'd0, 0, 0, 0, 0, S_RUN,   0, 2, 9));
    apply(mk("door_pause",  0, 4'd0, 0, 0, 0, 1, S_PAUSE, 0, 2, 9));
    apply(mk("door_start",  0, 4'd0, 1, 0, 0, 1, S_PAUSE, 0, 2, 9));
    apply(mk("door_shut",   0, 4'd0, 0, 0, 0, 0, S_PAUSE, 0, 2, 9));
    apply(mk("resume",      0, 4'd0, 1, 0, 0, 0, S_RUN,   0, 2, 9));
    for (int i = 0; i < 3; i++) apply(mk("resume_wait", 0, 4'd0, 0, 0, 0, 0, S_RUN, 0, 2, 9));
    apply(mk("resume_tick", 0, 4'd0, 0, 0, 0, 0, S_RUN,   0, 2, 8));
    apply(mk("pause_strb",  0, 4'd0, 0, 1, 0, 0, S_PAUSE, 0, 2, 8));
    apply(mk("pause_key",   1, 4'd5, 0, 0, 0, 0, S_PAUSE, 0, 2, 8));
    apply(mk("pause_again", 0, 4'd0, 0, 1, 0, 0, S_PAUSE, 0, 2, 8));
    apply(mk("clr_start",   0, 4'd0, 1, 0, 1, 0, S_IDLE,  0, 0, 0));

    // Door opened during the beep returns to IDLE at once.
    apply(mk("b_k1",        1, 4'd1, 0, 0, 0, 0, S_IDLE,  0, 0, 1));
    apply(mk("b_start",     0, 4'd0, 1, 0, 0, 0, S_RUN,   0, 0, 1));
    for (int i = 0; i < 3; i++) apply(mk("b_run", 0, 4'd0, 0, 0, 0, 0, S_RUN, 0, 0, 1));
    apply(mk("b_done",      0, 4'd0, 0, 0, 0, 0, S_DONE,  0, 0, 0));
    apply(mk("b_beep",      0, 4'd0, 0, 0, 0, 0, S_DONE,  0, 0, 0));
    apply(mk("b_door",      0, 4'd0, 0, 0, 0, 1, S_IDLE,  0, 0, 0));

    // Asynchronous reset while running at 3:27.
    apply(mk("r_k3",        1, 4'd3, 0, 0, 0, 0, S_IDLE,  0, 0, 3));
    apply(mk("r_k2",        1, 4'd2, 0, 0, 0, 0, S_IDLE,  0, 3, 2));
    apply(mk("r_k7",        1, 4'd7, 0, 0, 0, 0, S_IDLE,  3, 2, 7));
    apply(mk("r_start",     0, 4'd0, 1, 0, 0, 0, S_RUN,   3, 2, 7));
    apply(mk("r_run",       0, 4'd0, 0, 0, 0, 0, S_RUN,   3, 2, 7));
    @(negedge clk);
    key_valid = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; door_open = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (outs() !== pk(S_IDLE, 4'd0, 4'd0, 4'd0)) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", outs(), pk(S_IDLE, 4'd0, 4'd0, 4'd0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("after_reset", 0, 4'd0, 0, 0, 0, 0, S_IDLE,  0, 0, 0));

    n_tests++;
    if (sb_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
